// File: rtl/bus_resp_demux_4out_if.sv
// rtl/bus_resp_demux_4out_if.sv - shared-bus input and four-port output signal bundle
interface bus_resp_demux_4out_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                in_dest;
  logic [DATA_WIDTH-1:0]     in_data;
  logic [3:0]                out_valid;
  logic [3:0]                out_ready;
  logic [4*DATA_WIDTH-1:0]   out_data;
  logic [3:0]                fifo_full;

  modport master (
    output in_valid, in_dest, in_data, out_ready,
    input  in_ready, out_valid, out_data, fifo_full
  );

  modport slave (
    input  in_valid, in_dest, in_data, out_ready,
    output in_ready, out_valid, out_data, fifo_full
  );
endinterface

// File: rtl/bus_resp_demux_4out.sv
// rtl/bus_resp_demux_4out.sv - routes shared-bus words into four independent per-port FIFOs
module bus_resp_demux_4out #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  bus_resp_demux_4out_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Full status alone gates acceptance, so a same-cycle pop never frees a full port early.
  assign bus.in_ready = ~bus.fifo_full[bus.in_dest];

  for (genvar i = 0; i < 4; i++) begin : g_port
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  push;
    logic                  pop;

    assign push = bus.in_valid && bus.in_ready && (bus.in_dest == 2'(i));
    assign pop  = bus.out_valid[i] && bus.out_ready[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    // Storage is left unreset; a flushed count makes stale entries invisible.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.in_data;
    end

    assign bus.out_valid[i] = (cnt != '0);
    assign bus.fifo_full[i] = (cnt == FULL_CNT);
    assign bus.out_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr];
  end
endmodule

// File: tb/tb_bus_resp_demux_4out.sv
// tb/tb_bus_resp_demux_4out.sv - directed self-checking bench for bus_resp_demux_4out
module tb_bus_resp_demux_4out;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bus_resp_demux_4out_if #(.DATA_WIDTH(DW)) bus ();

  bus_resp_demux_4out #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] port_data(input int p);
    return bus.out_data[p*DW +: DW];
  endfunction

  logic [DW-1:0] fan_words [4];
  logic [DW-1:0] exp_q [$];
  int mc, next_w, got_w;
  logic toggle, acc, pp;

  initial begin
    checks = 0;
    errors = 0;
    fan_words[0] = 32'hF000;
    fan_words[1] = 32'h0F00;
    fan_words[2] = 32'h00F0;
    fan_words[3] = 32'h000F;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_dest   = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 4'b0000);
    check("rst_fifo_full", bus.fifo_full, 4'b0000);
    check("rst_in_ready", bus.in_ready, 1'b1);
    tick;
    rst_n = 1'b1;

    // single route to port 2, first handshake right after reset release
    bus.in_valid = 1'b1; bus.in_dest = 2'd2; bus.in_data = 32'hF000;
    #1 check("single_in_ready", bus.in_ready, 1'b1);
    tick;
    bus.in_valid = 1'b0; bus.in_dest = 2'd0; bus.in_data = 32'hDEAD;
    check("single_out_valid", bus.out_valid, 4'b0100);
    check("single_data", port_data(2), 32'hF000);
    bus.out_ready = 4'b0100;
    tick;
    bus.out_ready = 4'b0000;
    check("single_drained", bus.out_valid, 4'b0000);

    // fan-out to all four ports
    for (int d = 0; d < 4; d++) begin
      bus.in_valid = 1'b1; bus.in_dest = 2'(d); bus.in_data = fan_words[d];
      tick;
    end
    bus.in_valid = 1'b0;
    check("fan_out_valid", bus.out_valid, 4'b1111);
    for (int d = 0; d < 4; d++) check($sformatf("fan_data%0d", d), port_data(d), fan_words[d]);
    bus.out_ready = 4'b1111;
    tick;
    bus.out_ready = 4'b0000;
    check("fan_drained", bus.out_valid, 4'b0000);

    // full and backpressure on port 1
    bus.in_valid = 1'b1; bus.in_dest = 2'd1; bus.in_data = 32'hA1; tick;
    bus.in_data = 32'hA2; tick;
    check("full_flags", bus.fifo_full, 4'b0010);
    check("full_ready_d1", bus.in_ready, 1'b0);
    bus.in_dest = 2'd0; #1;
    check("full_ready_d0", bus.in_ready, 1'b1);
    bus.in_dest = 2'd1; bus.in_data = 32'hA3; tick;
    check("full_held_data", port_data(1), 32'hA1);
    check("full_held_flag", bus.fifo_full, 4'b0010);
    bus.out_ready = 4'b0010; #1;
    check("full_pop_ready", bus.in_ready, 1'b0);
    tick;
    bus.out_ready = 4'b0000;
    check("full_after_pop", port_data(1), 32'hA2);
    check("full_after_pop_flag", bus.fifo_full, 4'b0000);
    check("full_after_pop_rdy", bus.in_ready, 1'b1);
    tick;
    bus.in_valid = 1'b0;
    check("full_third_in", bus.fifo_full, 4'b0010);
    check("full_head", port_data(1), 32'hA2);
    bus.out_ready = 4'b0010;
    tick;
    check("full_pop3", port_data(1), 32'hA3);
    tick;
    bus.out_ready = 4'b0000;
    check("full_drained", bus.out_valid, 4'b0000);

    // wrap and ordering on port 3 with toggling consumer
    mc = 0; next_w = 1; got_w = 0; toggle = 1'b0;
    for (int cyc = 0; cyc < 60 && got_w < 10; cyc++) begin
      bus.in_valid     = (next_w <= 10);
      bus.in_dest      = 2'd3;
      bus.in_data      = DW'(next_w);
      bus.out_ready[3] = toggle;
      toggle           = ~toggle;
      @(negedge clk);
      check("wrap_ready", bus.in_ready, mc < DEPTH);
      check("wrap_valid", bus.out_valid[3], mc != 0);
      check("wrap_full", bus.fifo_full[3], mc == DEPTH);
      acc = bus.in_valid && (mc < DEPTH);
      pp  = (mc != 0) && bus.out_ready[3];
      if (pp) begin
        check("wrap_data", port_data(3), exp_q[0]);
        void'(exp_q.pop_front());
        got_w++;
      end
      if (acc) begin
        exp_q.push_back(DW'(next_w));
        next_w++;
      end
      mc = mc + int'(acc) - int'(pp);
      tick;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 4'b0000;
    check("wrap_count", got_w, 10);

    // simultaneous push and pop on port 0
    bus.in_valid = 1'b1; bus.in_dest = 2'd0; bus.in_data = 32'hB1; tick;
    bus.in_data = 32'hB2; bus.out_ready = 4'b0001; tick;
    bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
    check("sim_valid", bus.out_valid, 4'b0001);
    check("sim_full", bus.fifo_full, 4'b0000);
    check("sim_data", port_data(0), 32'hB2);
    bus.out_ready = 4'b0001; tick;
    bus.out_ready = 4'b0000;
    check("sim_drained", bus.out_valid, 4'b0000);

    // reset mid-stream with ports 1 and 2 holding words
    bus.in_valid = 1'b1; bus.in_dest = 2'd1; bus.in_data = 32'hC1; tick;
    bus.in_dest = 2'd2; bus.in_data = 32'hC2; tick;
    bus.in_valid = 1'b0;
    check("rstm_before", bus.out_valid, 4'b0110);
    #2 rst_n = 1'b0;
    #1;
    check("rstm_valid", bus.out_valid, 4'b0000);
    check("rstm_full", bus.fifo_full, 4'b0000);
    check("rstm_ready", bus.in_ready, 1'b1);
    #2 rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.in_dest = 2'd0; bus.in_data = 32'hC3; tick;
    bus.in_valid = 1'b0;
    check("rstm_after_valid", bus.out_valid, 4'b0001);
    check("rstm_after_data", port_data(0), 32'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_resp_demux_4out.md
BUS_RESP_DEMUX_4OUT -- requirements
Module: bus_resp_demux_4out

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of each data word.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the per-port FIFO depth in entries (power of two, >= 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the shared-bus word is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-007 The block SHALL have port in_dest, input, 2 bits: the destination port index 0..3.
REQ-008 The block SHALL have port in_data, input, DATA_WIDTH bits: the shared-bus payload.
REQ-009 The block SHALL have port out_valid, output, 4 bits: bit i means port i holds a word.
REQ-010 The block SHALL have port out_ready, input, 4 bits: bit i means the port i consumer takes the word.
REQ-011 The block SHALL have port out_data, output, 4*DATA_WIDTH bits: port i data is in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 The block SHALL have port fifo_full, output, 4 bits: bit i means the port i FIFO holds DEPTH entries.

Function
REQ-013 Each output port SHALL own an independent FIFO of DEPTH entries, built from a write pointer, a read pointer and an occupancy count of log2(DEPTH)+1 bits.
REQ-014 in_ready SHALL be combinational and SHALL equal ~fifo_full[in_dest], independent of in_valid.
REQ-015 A push SHALL occur to FIFO[in_dest] on a rising edge where in_valid && in_ready; in_data SHALL be written at the write pointer, and the write pointer and count SHALL then increment.
REQ-016 Words with in_valid low SHALL be ignored, whatever the values of in_dest and in_data.
REQ-017 out_valid[i] SHALL be 1 exactly when count[i] != 0; out_data for port i SHALL present the entry at the read pointer, registered (not a write-through).
REQ-018 A pop SHALL occur on a rising edge where out_valid[i] && out_ready[i]; the read pointer SHALL then increment and count[i] SHALL decrement.
REQ-019 Latency from an input handshake at edge N to out_valid at the destination SHALL be 1 cycle: the word is visible after edge N.
REQ-020 Pointers SHALL wrap modulo DEPTH without a gap, and per-port order SHALL be strictly FIFO.
REQ-021 A simultaneous push and pop on the same port SHALL leave the count unchanged and advance both pointers.
REQ-022 When a port is full, in_ready SHALL stay 0 for that destination even if a pop occurs on the same cycle; pushing into a full FIFO SHALL be impossible.
REQ-023 out_ready[i] asserted while out_valid[i]=0 SHALL have no effect, so an empty FIFO never underflows.
REQ-024 One port being full SHALL NOT block words addressed to the other ports.
REQ-025 No word SHALL be dropped, duplicated or delivered to a port other than in_dest.
REQ-026 in_data and in_dest SHALL be sampled only on the handshake edge.

Reset
REQ-027 While rst_n=0, all pointers and counts SHALL be 0, out_valid SHALL be 4'b0000, fifo_full SHALL be 4'b0000, and in_ready SHALL be 1.
REQ-028 Assertion of rst_n mid-operation SHALL immediately flush all FIFOs and discard stored words, and no pop SHALL be signalled for them.
REQ-029 The FIFO data storage SHALL NOT require reset; out_data content while out_valid=0 is don't-care.
REQ-030 After rst_n deasserts, the first handshake SHALL be accepted on the first rising edge.

Verification
REQ-031 The bench SHALL cover this single route: push 32'hF000 to dest 2 with out_ready=4'b0000 -> after 1 edge, out_valid=4'b0100, port 2 data=32'hF000, other ports show out_valid 0.
REQ-032 The bench SHALL cover fan-out: push 32'hF000, 32'h0F00, 32'h00F0 and 32'h000F to dests 0,1,2,3 on consecutive cycles -> out_valid=4'b1111 and each port holds its word, with no cross-delivery.
REQ-033 The bench SHALL cover full/backpressure: with out_ready=0, push 3 words to dest 1 with DEPTH=2 -> first two accepted, fifo_full[1]=1, in_ready=0 for dest 1 and 1 for dest 0, and the third word is held until a pop, then accepted.
REQ-034 The bench SHALL cover wrap and ordering: stream 10 words, 32'h1 to 32'hA, to dest 3 with out_ready[3] toggling every cycle -> port 3 delivers 1..A in order and no count exceeds DEPTH.
REQ-035 The bench SHALL cover simultaneous push/pop: with port 0 holding 1 word, push and pop in the same cycle -> count stays 1 and the new word is presented next.
REQ-036 The bench SHALL cover reset mid-stream: with two ports non-empty, pulse rst_n low for 3 ns between edges -> out_valid=0 and fifo_full=0 at once, and the next push after release is delivered normally.
